// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, direction bit indices, probe FSM
// states and the row*40+col tile index helper.
package game_pkg;

    localparam int DIR_DOWN  = 0;
    localparam int DIR_UP    = 1;
    localparam int DIR_RIGHT = 2;
    localparam int DIR_LEFT  = 3;

    localparam logic signed [10:0] SCREEN_W   = 11'sd640;
    localparam logic signed [10:0] SCREEN_H   = 11'sd480;
    localparam int                 TILE_SHIFT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // A 40-column map lets row*40 be built from two shifts and an add.
    function automatic logic [10:0] tile_index(input logic [10:0] row, input logic [10:0] col);
        return (row << 5) + (row << 3) + col;
    endfunction

endpackage

// File: rtl/probe_point_gen.sv
// Combinational probe-point generator: maps probe index k and the latched
// character position to a map tile address plus an out-of-screen flag.
module probe_point_gen
    import game_pkg::*;
#(
    parameter int CHAR_W   = 16,
    parameter int CHAR_H   = 16,
    parameter int MAP_COLS = 40,
    parameter int MAP_ROWS = 30
) (
    input  logic [2:0]  k_i,
    input  logic [9:0]  px_i,
    input  logic [8:0]  py_i,
    output logic [10:0] addr_o,
    output logic        oob_o
);

    localparam logic signed [10:0] CW = 11'(CHAR_W);
    localparam logic signed [10:0] CH = 11'(CHAR_H);
    localparam int MAP_W = MAP_COLS << TILE_SHIFT;
    localparam int MAP_H = MAP_ROWS << TILE_SHIFT;
    // The probe area is whichever of the map and the screen is smaller.
    localparam logic signed [10:0] X_LIM = 11'((MAP_W < int'(SCREEN_W)) ? MAP_W : int'(SCREEN_W));
    localparam logic signed [10:0] Y_LIM = 11'((MAP_H < int'(SCREEN_H)) ? MAP_H : int'(SCREEN_H));

    logic signed [10:0] x0_s;
    logic signed [10:0] y0_s;
    logic signed [10:0] x_s;
    logic signed [10:0] y_s;
    logic [10:0]        col_s;
    logic [10:0]        row_s;

    // Select the edge point for probe k, then convert it to a tile address.
    always_comb begin
        x0_s = $signed({1'b0, px_i});
        y0_s = $signed({2'b00, py_i});
        x_s  = x0_s;
        y_s  = y0_s;
        case (k_i)
            3'd0:    begin x_s = x0_s;              y_s = y0_s + CH;          end
            3'd1:    begin x_s = x0_s + CW - 11'sd1; y_s = y0_s + CH;          end
            3'd2:    begin x_s = x0_s;              y_s = y0_s - 11'sd1;      end
            3'd3:    begin x_s = x0_s + CW - 11'sd1; y_s = y0_s - 11'sd1;      end
            3'd4:    begin x_s = x0_s + CW;         y_s = y0_s;               end
            3'd5:    begin x_s = x0_s + CW;         y_s = y0_s + CH - 11'sd1; end
            3'd6:    begin x_s = x0_s - 11'sd1;     y_s = y0_s;               end
            3'd7:    begin x_s = x0_s - 11'sd1;     y_s = y0_s + CH - 11'sd1; end
            default: begin x_s = x0_s;              y_s = y0_s;               end
        endcase
        col_s  = 11'(x_s >>> TILE_SHIFT);
        row_s  = 11'(y_s >>> TILE_SHIFT);
        oob_o  = x_s[10] | y_s[10] | (x_s >= X_LIM) | (y_s >= Y_LIM);
        if (oob_o) begin
            addr_o = 11'd0;
        end else begin
            addr_o = tile_index(row_s, col_s);
        end
    end

endmodule

// File: rtl/collision_probe.sv
// Per-frame collision probe: sweeps 8 edge points through a 1-cycle map ROM
// and reports a down/up/right/left blocked vector. Define OOB_SOLID_EN to
// treat off-screen probes as solid.
module collision_probe
    import game_pkg::*;
#(
    parameter int CHAR_W   = 16,
    parameter int CHAR_H   = 16,
    parameter int MAP_COLS = 40,
    parameter int MAP_ROWS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  current_x,
    input  logic [8:0]  current_y,
    output logic [10:0] map_addr,
    input  logic        map_data,
    output logic [3:0]  collision_state,
    output logic        busy,
    output logic        done
);

`ifdef OOB_SOLID_EN
    localparam logic OOB_HIT = 1'b1;
`else
    localparam logic OOB_HIT = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [9:0]  px_q, px_d;
    logic [8:0]  py_q, py_d;
    logic [10:0] addr_q, addr_d;
    logic        oob_q, oob_d;
    logic        pend_valid_q, pend_valid_d;
    logic [1:0]  pend_dir_q, pend_dir_d;
    logic        pend_oob_q, pend_oob_d;
    logic [3:0]  acc_q, acc_d;
    logic [3:0]  cs_q, cs_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [2:0]  gen_k_s;
    logic [9:0]  gen_px_s;
    logic [8:0]  gen_py_s;
    logic [10:0] gen_addr_s;
    logic        gen_oob_s;
    logic        hit_s;
    logic [3:0]  acc_upd_s;

    // Addresses are registered, so the generator looks one probe ahead and,
    // while idle, works straight from the live position for probe 0.
    always_comb begin
        if (state_q == IDLE) begin
            gen_k_s  = 3'd0;
            gen_px_s = current_x;
            gen_py_s = current_y;
        end else begin
            gen_k_s  = 3'(k_q + 3'd1);
            gen_px_s = px_q;
            gen_py_s = py_q;
        end
    end

    probe_point_gen #(
        .CHAR_W   (CHAR_W),
        .CHAR_H   (CHAR_H),
        .MAP_COLS (MAP_COLS),
        .MAP_ROWS (MAP_ROWS)
    ) u_gen (
        .k_i    (gen_k_s),
        .px_i   (gen_px_s),
        .py_i   (gen_py_s),
        .addr_o (gen_addr_s),
        .oob_o  (gen_oob_s)
    );

    // Next-state logic: sweep FSM plus folding of the returning tile flag.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        px_d         = px_q;
        py_d         = py_q;
        addr_d       = addr_q;
        oob_d        = oob_q;
        pend_valid_d = 1'b0;
        pend_dir_d   = pend_dir_q;
        pend_oob_d   = pend_oob_q;
        acc_d        = acc_q;
        cs_d         = cs_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        hit_s = pend_oob_q ? OOB_HIT : map_data;
        if (pend_valid_q && hit_s) begin
            acc_upd_s = acc_q | (4'b0001 << pend_dir_q);
        end else begin
            acc_upd_s = acc_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PROBE;
                    px_d    = current_x;
                    py_d    = current_y;
                    k_d     = 3'd0;
                    acc_d   = 4'b0000;
                    addr_d  = gen_addr_s;
                    oob_d   = gen_oob_s;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PROBE: begin
                pend_valid_d = 1'b1;
                pend_dir_d   = k_q[2:1];
                pend_oob_d   = oob_q;
                acc_d        = acc_upd_s;
                if (k_q == 3'd7) begin
                    state_d = DRAIN;
                    addr_d  = 11'd0;
                    oob_d   = 1'b0;
                end else begin
                    k_d    = 3'(k_q + 3'd1);
                    addr_d = gen_addr_s;
                    oob_d  = gen_oob_s;
                end
            end
            DRAIN: begin
                acc_d   = acc_upd_s;
                cs_d    = acc_upd_s;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; the character starts grounded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= 3'd0;
            px_q         <= 10'd0;
            py_q         <= 9'd0;
            addr_q       <= 11'd0;
            oob_q        <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= 2'd0;
            pend_oob_q   <= 1'b0;
            acc_q        <= 4'b0000;
            cs_q         <= 4'b0001;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            px_q         <= px_d;
            py_q         <= py_d;
            addr_q       <= addr_d;
            oob_q        <= oob_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            pend_oob_q   <= pend_oob_d;
            acc_q        <= acc_d;
            cs_q         <= cs_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign map_addr        = addr_q;
    assign collision_state = cs_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_collision_probe.sv
// Self-checking bench for collision_probe: a geometric sweep model checked
// every cycle, plus hand-computed address/result pins. Honours OOB_SOLID_EN.
module tb_collision_probe;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  current_x;
    logic [8:0]  current_y;
    logic [10:0] map_addr;
    logic        map_data = 1'b0;
    logic [3:0]  collision_state;
    logic        busy;
    logic        done;

`ifdef OOB_SOLID_EN
    localparam logic OOB_SOLID = 1'b1;
`else
    localparam logic OOB_SOLID = 1'b0;
`endif

    collision_probe dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .current_x       (current_x),
        .current_y       (current_y),
        .map_addr        (map_addr),
        .map_data        (map_data),
        .collision_state (collision_state),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    logic solid [0:2047];
    always @(posedge clk) map_data <= solid[map_addr];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase is the cycle number within a sweep (1..10), -1 when idle.
    int         phase = -1;
    int         exp_addr [8];
    logic [3:0] result;
    logic [3:0] exp_cs = 4'b0001;
    int         cap [8];

    task automatic model_sweep(input int x, input int y);
        int xs [8];
        int ys [8];
        bit oob;
        bit hit;
        xs = '{x, x + 15, x, x + 15, x + 16, x + 16, x - 1, x - 1};
        ys = '{y + 16, y + 16, y - 1, y - 1, y, y + 15, y, y + 15};
        result = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            oob = (xs[i] < 0) || (xs[i] >= 640) || (ys[i] < 0) || (ys[i] >= 480);
            exp_addr[i] = oob ? 0 : (ys[i] / 16) * 40 + (xs[i] / 16);
            hit = oob ? OOB_SOLID : solid[exp_addr[i]];
            if (hit) result[i / 2] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            phase  = -1;
            exp_cs = 4'b0001;
        end else if (phase == -1) begin
            if (start) begin
                model_sweep(int'(current_x), int'(current_y));
                phase = 1;
            end
        end else if (phase == 10) begin
            phase = -1;
        end else begin
            phase = phase + 1;
            if (phase == 10) exp_cs = result;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("busy", busy, (phase >= 1 && phase <= 10));
            check("done", done, (phase == 10));
            check("collision_state", collision_state, exp_cs);
            if (phase >= 1 && phase <= 8) begin
                check("map_addr", map_addr, exp_addr[phase - 1]);
                cap[phase - 1] = int'(map_addr);
            end
            if (done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input int x, input int y);
        current_x = 10'(x);
        current_y = 9'(y);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_sweep(input int x, input int y);
        done_cnt = 0;
        pulse_start(x, y);
        repeat (11) step();
        check("one_done_pulse", done_cnt, 1);
    endtask

    task automatic check_caps(input string name, input int e0, input int e1, input int e2, input int e3,
                              input int e4, input int e5, input int e6, input int e7);
        int e [8];
        e = '{e0, e1, e2, e3, e4, e5, e6, e7};
        for (int i = 0; i < 8; i++) check(name, cap[i], e[i]);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) solid[i] = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        current_x = 10'd0;
        current_y = 9'd0;
        repeat (3) step();
        check("reset_map_addr", map_addr, 11'd0);
        check("reset_state", collision_state, 4'b0001);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        rst = 1'b0;
        checking = 1'b1;
        step();

        // Unaligned position on an empty map.
        run_sweep(100, 200);
        check_caps("addr_100_200", 526, 527, 486, 487, 487, 527, 486, 526);
        check("empty_100_200", collision_state, 4'b0000);

        // Tile-aligned position.
        run_sweep(96, 192);
        check_caps("addr_96_192", 526, 526, 446, 446, 487, 487, 485, 485);

        solid[526] = 1'b1;
        run_sweep(96, 192);
        check("floor_tile_526", collision_state, 4'b0001);
        check("busy_after_done", busy, 1'b0);
        solid[526] = 1'b0;

        // Top-left corner; tile 0 is solid but OOB probes must not read it.
        solid[0] = 1'b1;
        run_sweep(0, 0);
        check("corner_0_0", collision_state, OOB_SOLID ? 4'b1010 : 4'b0000);
        solid[0] = 1'b0;

        run_sweep(624, 464);
        check("corner_624_464", collision_state, OOB_SOLID ? 4'b0101 : 4'b0000);

        // Up/right/left walls; position moves mid-sweep without effect.
        solid[486] = 1'b1;
        solid[487] = 1'b1;
        done_cnt = 0;
        pulse_start(100, 200);
        current_x = 10'd300;
        current_y = 9'd50;
        repeat (11) step();
        check("walls_done_pulse", done_cnt, 1);
        check("walls_100_200", collision_state, 4'b1110);

        // start in cycle 4 of a sweep is ignored.
        done_cnt = 0;
        pulse_start(96, 192);
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        check("ignored_start_done", done_cnt, 1);
        check("ignored_start_busy", busy, 1'b0);

        // Reset in cycle 5 aborts the sweep.
        done_cnt = 0;
        pulse_start(100, 200);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_state", collision_state, 4'b0001);
        repeat (10) step();
        check("abort_no_done", done_cnt, 0);

        run_sweep(100, 200);
        check("after_abort", collision_state, 4'b1110);

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
